// File: rtl/irrigation_sequencer_pkg.sv
// Shared definitions for the irrigation sequencer: phase encodings,
// irrigation mode encodings and BCD helpers.
package irrigation_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE     = 3'b000,
    PH_FILL     = 3'b001,
    PH_IRRIGATE = 3'b010,
    PH_CLEAN    = 3'b011,
    PH_HOLD     = 3'b100,
    PH_FAULT    = 3'b101
  } phase_t;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_DRIP = 2'b01;

  localparam logic [7:0] BCD_ZERO = 8'h00;
  localparam logic [7:0] BCD_ONE  = 8'h01;

  // Convert a 0..99 integer into two packed BCD digits {tens, units}.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/irrigation_sequencer_bcd_down_counter.sv
// Two-digit BCD down counter with load, decrement and hold.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   load          load load_val (has priority over dec)
//   dec           decrement by one, saturating at 00
//   load_val      value to load, {tens, units}
//   value         registered count, {tens, units}
//   value_nxt_c   value after this edge (combinational)
//   is_one_c      count equals 01 (combinational)
module bcd_down_counter
  import irrigation_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic [7:0] value_nxt_c,
  output logic       is_one_c
);

  // Next count: units wrap 0 -> 9 with a borrow from the tens digit.
  always_comb begin
    value_nxt_c = value;
    if (load) begin
      value_nxt_c = load_val;
    end else if (dec && (value != BCD_ZERO)) begin
      if (value[3:0] == 4'd0) begin
        value_nxt_c = {value[7:4] - 4'd1, 4'd9};
      end else begin
        value_nxt_c = {value[7:4], value[3:0] - 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= BCD_ZERO;
    end else begin
      value <= value_nxt_c;
    end
  end

  assign is_one_c = (value == BCD_ONE);

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation run sequencer: tank fill, line-by-line irrigation, cleaning
// flush, completion. Advances on a 1 Hz enable; pauses while the pesticide
// check fails.
// Ports:
//   clk_50mhz, rst_n     clock, async active-low reset
//   start, abort         one-cycle run control pulses
//   irr_mode             00 none, 01 drip, 10/11 sprinkler
//   tick_1hz             one-cycle enable per second
//   tank_full/empty      level sensors
//   pesticide_ok         1 = run may proceed
//   line_en              line valve enables (one-hot while irrigating)
//   valve_fill, pump_on  actuators
//   phase                current state encoding
//   remain_tens/units    BCD seconds remaining for the display
//   busy, done, fault    status
module irrigation_sequencer
  import irrigation_sequencer_pkg::*;
#(
  parameter int unsigned N_LINES        = 7,
  parameter int unsigned DRIP_SECS      = 12,
  parameter int unsigned SPRINKLER_SECS = 6,
  parameter int unsigned CLEAN_SECS     = 5,
  parameter int unsigned FILL_TIMEOUT   = 30
) (
  input  logic               clk_50mhz,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         irr_mode,
  input  logic               tick_1hz,
  input  logic               tank_full,
  input  logic               tank_empty,
  input  logic               pesticide_ok,
  output logic [N_LINES-1:0] line_en,
  output logic               valve_fill,
  output logic               pump_on,
  output logic [2:0]         phase,
  output logic [3:0]         remain_tens,
  output logic [3:0]         remain_units,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  localparam int unsigned IDX_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LINES - 1);
  localparam logic [7:0] DRIP_BCD      = to_bcd(DRIP_SECS);
  localparam logic [7:0] SPRINKLER_BCD = to_bcd(SPRINKLER_SECS);
  localparam logic [7:0] CLEAN_BCD     = to_bcd(CLEAN_SECS);
  localparam logic [7:0] TIMEOUT_BCD   = to_bcd(FILL_TIMEOUT);

  phase_t           state, state_n;
  phase_t           hold_state, hold_state_n;
  logic [1:0]       mode, mode_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             res_valid, res_valid_n;
  logic [IDX_W-1:0] res_idx, res_idx_n;
  logic [7:0]       res_rem, res_rem_n;
  logic             done_n;

  logic             cnt_load, cnt_dec;
  logic [7:0]       cnt_load_val, cnt_value, cnt_nxt;
  logic             cnt_is_one;

  logic [N_LINES-1:0] line_en_n;
  logic [7:0]         disp_n;

  function automatic logic [7:0] dwell(input logic [1:0] m);
    return (m == MODE_DRIP) ? DRIP_BCD : SPRINKLER_BCD;
  endfunction

  // One counter serves dwell, clean and fill-timeout; an interrupted
  // irrigation position is parked in res_* while FILL reuses it.
  bcd_down_counter u_cnt (
    .clk         (clk_50mhz),
    .rst_n       (rst_n),
    .load        (cnt_load),
    .dec         (cnt_dec),
    .load_val    (cnt_load_val),
    .value       (cnt_value),
    .value_nxt_c (cnt_nxt),
    .is_one_c    (cnt_is_one)
  );

  // State register.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PH_IDLE;
      hold_state <= PH_IDLE;
      mode       <= MODE_NONE;
      idx        <= '0;
      res_valid  <= 1'b0;
      res_idx    <= '0;
      res_rem    <= BCD_ZERO;
    end else begin
      state      <= state_n;
      hold_state <= hold_state_n;
      mode       <= mode_n;
      idx        <= idx_n;
      res_valid  <= res_valid_n;
      res_idx    <= res_idx_n;
      res_rem    <= res_rem_n;
    end
  end

  // Next state; priority abort > pesticide > tank sensors > tick.
  always_comb begin
    state_n      = state;
    hold_state_n = hold_state;
    mode_n       = mode;
    idx_n        = idx;
    res_valid_n  = res_valid;
    res_idx_n    = res_idx;
    res_rem_n    = res_rem;
    done_n       = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = BCD_ZERO;

    if (abort) begin
      state_n      = PH_IDLE;
      hold_state_n = PH_IDLE;
      idx_n        = '0;
      res_valid_n  = 1'b0;
      cnt_load     = 1'b1;
    end else begin
      unique case (state)
        PH_IDLE: begin
          if (start) begin
            mode_n = irr_mode;
            if (irr_mode == MODE_NONE) begin
              done_n = 1'b1;
            end else if (!tank_full) begin
              state_n      = PH_FILL;
              res_valid_n  = 1'b0;
              cnt_load     = 1'b1;
              cnt_load_val = TIMEOUT_BCD;
            end else begin
              state_n      = PH_IRRIGATE;
              idx_n        = '0;
              cnt_load     = 1'b1;
              cnt_load_val = dwell(irr_mode);
            end
          end
        end

        PH_FILL: begin
          if (!pesticide_ok) begin
            state_n      = PH_HOLD;
            hold_state_n = PH_FILL;
          end else if (tank_full) begin
            state_n     = PH_IRRIGATE;
            cnt_load    = 1'b1;
            res_valid_n = 1'b0;
            if (res_valid) begin
              idx_n        = res_idx;
              cnt_load_val = res_rem;
            end else begin
              idx_n        = '0;
              cnt_load_val = dwell(mode);
            end
          end else if (tick_1hz) begin
            if (cnt_is_one) begin
              state_n  = PH_FAULT;
              cnt_load = 1'b1;
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end

        PH_IRRIGATE: begin
          if (!pesticide_ok) begin
            state_n      = PH_HOLD;
            hold_state_n = PH_IRRIGATE;
          end else if (tank_empty) begin
            state_n      = PH_FILL;
            res_valid_n  = 1'b1;
            res_idx_n    = idx;
            res_rem_n    = cnt_value;
            cnt_load     = 1'b1;
            cnt_load_val = TIMEOUT_BCD;
          end else if (tick_1hz) begin
            if (cnt_is_one) begin
              cnt_load = 1'b1;
              if (idx == LAST_IDX) begin
                state_n      = PH_CLEAN;
                cnt_load_val = CLEAN_BCD;
              end else begin
                idx_n        = idx + IDX_W'(1);
                cnt_load_val = dwell(mode);
              end
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end

        PH_CLEAN: begin
          if (!pesticide_ok) begin
            state_n      = PH_HOLD;
            hold_state_n = PH_CLEAN;
          end else if (tick_1hz) begin
            if (cnt_is_one) begin
              state_n  = PH_IDLE;
              idx_n    = '0;
              done_n   = 1'b1;
              cnt_load = 1'b1;
            end else begin
              cnt_dec = 1'b1;
            end
          end
        end

        PH_HOLD: begin
          // Counter and index stay frozen; ticks are dropped here.
          if (pesticide_ok) begin
            state_n = hold_state;
          end
        end

        PH_FAULT: begin
          state_n = PH_FAULT;
        end

        default: begin
          state_n = PH_IDLE;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs track the state register.
  always_comb begin
    line_en_n = '0;
    if (state_n == PH_IRRIGATE) begin
      line_en_n = N_LINES'(1) << idx_n;
    end else if (state_n == PH_CLEAN) begin
      line_en_n = '1;
    end
    // The fill timeout count is internal; the display shows 00 during fill.
    disp_n = cnt_nxt;
    if ((state_n == PH_FILL) || ((state_n == PH_HOLD) && (hold_state_n == PH_FILL))) begin
      disp_n = BCD_ZERO;
    end
  end

  // Output registers.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      line_en      <= '0;
      valve_fill   <= 1'b0;
      pump_on      <= 1'b0;
      phase        <= PH_IDLE;
      remain_tens  <= 4'd0;
      remain_units <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      line_en      <= line_en_n;
      valve_fill   <= (state_n == PH_FILL);
      pump_on      <= (state_n == PH_IRRIGATE) || (state_n == PH_CLEAN);
      phase        <= state_n;
      remain_tens  <= disp_n[7:4];
      remain_units <= disp_n[3:0];
      busy         <= (state_n != PH_IDLE);
      done         <= done_n;
      fault        <= (state_n == PH_FAULT);
    end
  end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed table-driven bench for irrigation_sequencer with small timings.
module tb_irrigation_sequencer;

  localparam int unsigned N_LINES = 3;

  logic               clk_50mhz;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [1:0]         irr_mode;
  logic               tick_1hz;
  logic               tank_full;
  logic               tank_empty;
  logic               pesticide_ok;
  logic [N_LINES-1:0] line_en;
  logic               valve_fill;
  logic               pump_on;
  logic [2:0]         phase;
  logic [3:0]         remain_tens;
  logic [3:0]         remain_units;
  logic               busy;
  logic               done;
  logic               fault;

  int n_checks = 0;
  int n_pass   = 0;

  irrigation_sequencer #(
    .N_LINES        (N_LINES),
    .DRIP_SECS      (2),
    .SPRINKLER_SECS (1),
    .CLEAN_SECS     (2),
    .FILL_TIMEOUT   (4)
  ) dut (
    .clk_50mhz    (clk_50mhz),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .irr_mode     (irr_mode),
    .tick_1hz     (tick_1hz),
    .tank_full    (tank_full),
    .tank_empty   (tank_empty),
    .pesticide_ok (pesticide_ok),
    .line_en      (line_en),
    .valve_fill   (valve_fill),
    .pump_on      (pump_on),
    .phase        (phase),
    .remain_tens  (remain_tens),
    .remain_units (remain_units),
    .busy         (busy),
    .done         (done),
    .fault        (fault)
  );

  initial clk_50mhz = 1'b0;
  always #5 clk_50mhz = ~clk_50mhz;

  typedef struct {
    logic        st;
    logic        ab;
    logic [1:0]  md;
    logic        tk;
    logic        fl;
    logic        em;
    logic        pk;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Observed bundle: {phase, line_en, valve, pump, tens, units, busy, done, fault}
  function automatic logic [18:0] obs();
    return {phase, line_en, valve_fill, pump_on, remain_tens, remain_units, busy, done, fault};
  endfunction

  function automatic logic [18:0] expv(input logic [2:0] ph, input logic [2:0] ln,
                                        input logic vf, input logic pu, input logic [7:0] rem,
                                        input logic bz, input logic dn, input logic ft);
    return {ph, ln, vf, pu, rem, bz, dn, ft};
  endfunction

  function automatic vec_t mk(input logic st, input logic ab, input logic [1:0] md,
                              input logic tk, input logic fl, input logic em, input logic pk,
                              input logic [18:0] e);
    vec_t v;
    v.st = st; v.ab = ab; v.md = md; v.tk = tk;
    v.fl = fl; v.em = em; v.pk = pk; v.exp = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [18:0] act, input logic [18:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got {ph,ln,vf,pu,rem,busy,done,fault}=%b_%b_%b_%b_%h_%b_%b_%b required %b_%b_%b_%b_%h_%b_%b_%b",
               nm, act[18:16], act[15:13], act[12], act[11], act[10:3], act[2], act[1], act[0],
               exp[18:16], exp[15:13], exp[12], exp[11], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input vec_t v);
    start = v.st; abort = v.ab; irr_mode = v.md; tick_1hz = v.tk;
    tank_full = v.fl; tank_empty = v.em; pesticide_ok = v.pk;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; irr_mode = 2'b01; tick_1hz = 0;
    tank_full = 1; tank_empty = 0; pesticide_ok = 1;
  endtask

  localparam logic [18:0] ZERO = '0;

  initial begin
    logic [18:0] e_ir1, e_ir2, e_ir4, e_cl, e_fill, e_idle_done, e_fault;
    e_fill      = expv(3'b001, 3'b000, 1, 0, 8'h00, 1, 0, 0);
    e_idle_done = expv(3'b000, 3'b000, 0, 0, 8'h00, 0, 1, 0);
    e_fault     = expv(3'b101, 3'b000, 0, 0, 8'h00, 1, 0, 1);

    // Drip run with tank full.
    vecs.push_back(mk(1,0,2'b01,0,1,0,1, expv(3'b010,3'b001,0,1,8'h02,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,0,1,0,1, expv(3'b010,3'b001,0,1,8'h02,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b010,3'b001,0,1,8'h01,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b010,3'b010,0,1,8'h02,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b010,3'b010,0,1,8'h01,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b010,3'b100,0,1,8'h02,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b010,3'b100,0,1,8'h01,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b011,3'b111,0,1,8'h02,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b011,3'b111,0,1,8'h01,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, e_idle_done));
    vecs.push_back(mk(0,0,2'b01,0,1,0,1, ZERO));
    // Fill then irrigate.
    vecs.push_back(mk(1,0,2'b01,0,0,0,1, e_fill));
    vecs.push_back(mk(0,0,2'b01,1,0,0,1, e_fill));
    vecs.push_back(mk(0,0,2'b01,1,0,0,1, e_fill));
    vecs.push_back(mk(0,0,2'b01,0,1,0,1, expv(3'b010,3'b001,0,1,8'h02,1,0,0)));
    // Mid-run refill at line 1, remain 01.
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b010,3'b001,0,1,8'h01,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b010,3'b010,0,1,8'h02,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b010,3'b010,0,1,8'h01,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,0,0,1,1, e_fill));
    vecs.push_back(mk(0,0,2'b01,1,0,0,1, e_fill));
    vecs.push_back(mk(0,0,2'b01,0,1,0,1, expv(3'b010,3'b010,0,1,8'h01,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b010,3'b100,0,1,8'h02,1,0,0)));
    // Ticks coinciding with tank transitions are consumed.
    vecs.push_back(mk(0,0,2'b01,1,0,1,1, e_fill));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b010,3'b100,0,1,8'h02,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b010,3'b100,0,1,8'h01,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b011,3'b111,0,1,8'h02,1,0,0)));
    // Pesticide hold during CLEAN.
    vecs.push_back(mk(0,0,2'b01,0,1,0,0, expv(3'b100,3'b000,0,0,8'h02,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,0, expv(3'b100,3'b000,0,0,8'h02,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,0, expv(3'b100,3'b000,0,0,8'h02,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,0, expv(3'b100,3'b000,0,0,8'h02,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,0,1,0,1, expv(3'b011,3'b111,0,1,8'h02,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, expv(3'b011,3'b111,0,1,8'h01,1,0,0)));
    vecs.push_back(mk(0,0,2'b01,1,1,0,1, e_idle_done));
    // Fill timeout, start ignored in FAULT, abort.
    vecs.push_back(mk(1,0,2'b01,0,0,0,1, e_fill));
    vecs.push_back(mk(0,0,2'b01,1,0,0,1, e_fill));
    vecs.push_back(mk(0,0,2'b01,1,0,0,1, e_fill));
    vecs.push_back(mk(0,0,2'b01,1,0,0,1, e_fill));
    vecs.push_back(mk(0,0,2'b01,1,0,0,1, e_fault));
    vecs.push_back(mk(1,0,2'b01,0,0,0,1, e_fault));
    vecs.push_back(mk(0,1,2'b01,0,0,0,1, ZERO));
    vecs.push_back(mk(0,0,2'b01,0,1,0,1, ZERO));
    // Mode 00.
    vecs.push_back(mk(1,0,2'b00,0,1,0,1, e_idle_done));
    vecs.push_back(mk(0,0,2'b00,0,1,0,1, ZERO));
    // Mode 11 as sprinkler, pesticide priority over tank_empty, abort.
    vecs.push_back(mk(1,0,2'b11,0,1,0,1, expv(3'b010,3'b001,0,1,8'h01,1,0,0)));
    vecs.push_back(mk(0,0,2'b11,1,1,0,1, expv(3'b010,3'b010,0,1,8'h01,1,0,0)));
    vecs.push_back(mk(0,0,2'b11,1,1,1,0, expv(3'b100,3'b000,0,0,8'h01,1,0,0)));
    vecs.push_back(mk(0,0,2'b11,0,1,0,1, expv(3'b010,3'b010,0,1,8'h01,1,0,0)));
    vecs.push_back(mk(0,1,2'b11,1,1,0,1, ZERO));

    // Reset state.
    rst_n = 1'b0;
    idle_inputs();
    #2;
    check("reset_initial", obs(), ZERO);
    @(posedge clk_50mhz); #1;
    check("reset_held", obs(), ZERO);
    @(negedge clk_50mhz);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk_50mhz);
      drive(vecs[i]);
      @(posedge clk_50mhz); #1;
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // Asynchronous reset in the middle of IRRIGATE.
    @(negedge clk_50mhz);
    idle_inputs();
    start = 1'b1;
    @(posedge clk_50mhz); #1;
    e_ir2 = expv(3'b010, 3'b001, 0, 1, 8'h02, 1, 0, 0);
    check("pre_reset_irrigate", obs(), e_ir2);
    start = 1'b0;
    tick_1hz = 1'b1;
    @(posedge clk_50mhz); #1;
    e_ir1 = expv(3'b010, 3'b001, 0, 1, 8'h01, 1, 0, 0);
    check("pre_reset_tick", obs(), e_ir1);
    tick_1hz = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), ZERO);
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    @(posedge clk_50mhz); #1;
    check("post_reset_idle", obs(), ZERO);

    // Fresh sprinkler run after reset: nothing retained.
    @(negedge clk_50mhz);
    start = 1'b1;
    irr_mode = 2'b10;
    @(posedge clk_50mhz); #1;
    e_ir4 = expv(3'b010, 3'b001, 0, 1, 8'h01, 1, 0, 0);
    check("post_reset_start", obs(), e_ir4);
    start = 1'b0;
    abort = 1'b1;
    @(posedge clk_50mhz); #1;
    check("final_abort", obs(), ZERO);
    abort = 1'b0;
    e_cl = ZERO;
    @(posedge clk_50mhz); #1;
    check("final_idle", obs(), e_cl);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
